fifo_arb_ctrl: RTL and testbench

- Controller that shares the 8-entry, 8-bit synchronous FIFO buffer between two write requesters and drains it to one downstream consumer over a valid/ready handshake.
- Drives the FIFO's write_to_stack, read_from_stack and Data_in.
- Tracks occupancy internally, because the FIFO exposes no full/empty flags.
- Sits between producer logic and the FIFO instance.

---
 rtl/fifo_arb_ctrl.sv | 136 +++++++++++++
 tb/tb_fifo_arb_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arb_ctrl.sv
// Two-requester write arbiter and valid/ready read drain for an external 8-entry FIFO without flags.
// Define FIFO_ARB_STRICT_PRIO_EN for fixed priority (req0 wins); otherwise round-robin arbitration.
module fifo_arb_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int LW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          gnt1,
    output logic          fifo_wr,
    output logic [DW-1:0] fifo_din,
    output logic          fifo_rd,
    input  logic [DW-1:0] fifo_dout,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          valid_next;
    logic [DW-1:0] data_next;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

`ifdef FIFO_ARB_STRICT_PRIO_EN
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!full) begin
            gnt0 = req0;
            gnt1 = req1 && !req0;
        end
    end
`else
    // rr_last holds the most recent winner; reset to 0 so requester 1 goes first.
    logic rr_last;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!full) begin
            if (req0 && req1) begin
                gnt0 = rr_last;
                gnt1 = !rr_last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b0;
        end else if (gnt0 || gnt1) begin
            rr_last <= gnt1;
        end
    end
`endif

    assign fifo_wr  = gnt0 | gnt1;
    assign fifo_din = gnt0 ? data0 : (gnt1 ? data1 : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else if (fifo_wr && !fifo_rd) begin
            level <= level + 1'b1;
        end else if (!fifo_wr && fifo_rd) begin
            level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_next;
            out_valid <= valid_next;
            out_data  <= data_next;
        end
    end

    // FIFO read data arrives one cycle after fifo_rd, so FETCH is the capture cycle.
    always_comb begin
        state_next = state;
        fifo_rd    = 1'b0;
        valid_next = out_valid;
        data_next  = out_data;
        case (state)
            IDLE: begin
                if (!empty) begin
                    fifo_rd    = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                data_next  = fifo_dout;
                valid_next = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    if (!empty) begin
                        fifo_rd    = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Self-checking bench for fifo_arb_ctrl with a behavioural FIFO and a write-order scoreboard.
// Honours FIFO_ARB_STRICT_PRIO_EN to select the expected arbitration policy.
module tb_fifo_arb_ctrl;

    logic       clk;
    logic       rst;
    logic       req0, req1, gnt0, gnt1;
    logic [7:0] data0, data1;
    logic       fifo_wr, fifo_rd;
    logic [7:0] fifo_din, fifo_dout;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic [3:0] level;
    logic       full, empty;

    int compared   = 0;
    int mismatched = 0;

    fifo_arb_ctrl #(.DW(8), .DEPTH(8), .LW(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8x8 FIFO sharing the controller's reset, registered read data.
    logic [7:0] mem [8];
    logic [2:0] wp, rp;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            fifo_dout <= '0;
        end else begin
            if (fifo_wr) begin
                mem[wp] <= fifo_din;
                wp      <= wp + 3'd1;
            end
            if (fifo_rd) begin
                fifo_dout <= mem[rp];
                rp        <= rp + 3'd1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [7:0] d0, input logic r1,
                                 input logic [7:0] d1, input logic rdy);
        req0 = r0; data0 = d0; req1 = r1; data1 = d1; out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Cycle monitor: grant model, occupancy model and the byte-order scoreboard.
    int         model_occ = 0;
    logic       rr_last   = 1'b0;
    logic       exp_g0, exp_g1;
    logic [7:0] wdata, sb_exp;
    logic [7:0] sb [$];

    always @(negedge clk) begin
        if (rst) begin
            model_occ = 0;
            rr_last   = 1'b0;
            sb.delete();
        end else begin
            exp_g0 = 1'b0;
            exp_g1 = 1'b0;
            if (model_occ < 8) begin
                if (req0 && req1) begin
`ifdef FIFO_ARB_STRICT_PRIO_EN
                    exp_g0 = 1'b1;
`else
                    exp_g0 = rr_last;
                    exp_g1 = !rr_last;
`endif
                end else begin
                    exp_g0 = req0;
                    exp_g1 = req1;
                end
            end
            wdata = exp_g0 ? data0 : (exp_g1 ? data1 : 8'h00);
            checkOutput("gnt", 32'({gnt0, gnt1}), 32'({exp_g0, exp_g1}));
            checkOutput("fifo_wr", 32'(fifo_wr), 32'(exp_g0 | exp_g1));
            checkOutput("fifo_din", 32'(fifo_din), 32'(wdata));
            checkOutput("level", 32'(level), 32'(model_occ));
            checkOutput("full", 32'(full), 32'(model_occ == 8));
            checkOutput("empty", 32'(empty), 32'(model_occ == 0));
            if (fifo_rd) checkOutput("rd_nonempty", 32'(model_occ != 0), 32'd1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 32'd1, 32'd0);
                end else begin
                    sb_exp = sb.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(sb_exp));
                end
            end
            if (exp_g0 || exp_g1) begin
                sb.push_back(wdata);
                rr_last = exp_g1;
            end
            model_occ = model_occ + int'(exp_g0 | exp_g1) - int'(fifo_rd);
        end
    end

    logic       g0, g1;
    logic       win [9];
    int         n;
    int         got;
    int         last_t;
    logic [7:0] first_byte;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (3) step();
        rst = 1'b0;
        sample();
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_fifo_rd", 32'(fifo_rd), 32'd0);

        // Single write and its 3-cycle path to out_valid.
        step();
        applyStimulus(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
        sample();
        checkOutput("t1_gnt0", 32'(gnt0), 32'd1);
        checkOutput("t1_fifo_wr", 32'(fifo_wr), 32'd1);
        checkOutput("t1_fifo_din", 32'(fifo_din), 32'h11);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        sample();
        checkOutput("t1_fifo_rd", 32'(fifo_rd), 32'd1);
        step();
        sample();
        checkOutput("t1_valid_fetch", 32'(out_valid), 32'd0);
        step();
        sample();
        checkOutput("t1_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_data", 32'(out_data), 32'h11);
        checkOutput("t1_level", 32'(level), 32'd0);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        sample();
        checkOutput("t1_valid_after", 32'(out_valid), 32'd0);
        checkOutput("t1_empty", 32'(empty), 32'd1);

        // Both requesters held with the consumer stalled until the FIFO fills.
        step();
        applyStimulus(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            sample();
            g0 = gnt0;
            g1 = gnt1;
            if (g0 || g1) begin
                if (n < 9) win[n] = g1;
                n++;
            end
            step();
            if (g0) data0 = data0 + 8'd1;
            if (g1) data1 = data1 + 8'd1;
        end
        checkOutput("t2_grant_count", 32'(n), 32'd9);
        for (int i = 0; i < 9; i++) begin
`ifdef FIFO_ARB_STRICT_PRIO_EN
            checkOutput("t2_winner", 32'(win[i]), 32'd0);
`else
            checkOutput("t2_winner", 32'(win[i]), 32'((i % 2) == 0));
`endif
        end
`ifdef FIFO_ARB_STRICT_PRIO_EN
        first_byte = 8'hA0;
`else
        first_byte = 8'hB0;
`endif

        // Stalled consumer: output register stable, no further reads or writes.
        for (int c = 0; c < 20; c++) begin
            sample();
            checkOutput("t3_out_data", 32'(out_data), 32'(first_byte));
            checkOutput("t3_out_valid", 32'(out_valid), 32'd1);
            checkOutput("t3_level", 32'(level), 32'd8);
            checkOutput("t3_fifo_rd", 32'(fifo_rd), 32'd0);
            checkOutput("t3_no_gnt", 32'(gnt0 | gnt1), 32'd0);
            step();
        end

        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (40) step();
        sample();
        checkOutput("t3_drained_empty", 32'(empty), 32'd1);
        checkOutput("t3_drained_valid", 32'(out_valid), 32'd0);

        // Ordered sequence 0x01..0x08, then drained at one byte per two cycles.
        step();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            req0  = 1'b1;
            data0 = 8'(i);
            sample();
            checkOutput("t4_gnt0", 32'(gnt0), 32'd1);
            step();
        end
        req0 = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        got    = 0;
        last_t = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            sample();
            if (out_valid && out_ready) begin
                checkOutput("t4_seq", 32'(out_data), 32'(got + 1));
                if (got > 0) checkOutput("t4_gap", 32'(c - last_t), 32'd2);
                last_t = c;
                got++;
            end
            step();
        end
        checkOutput("t4_count", 32'(got), 32'd8);
        repeat (2) step();
        sample();
        checkOutput("t4_empty", 32'(empty), 32'd1);

        // Reset while holding a byte with five entries queued.
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req0  = 1'b1;
            data0 = 8'h40 + 8'(i);
            step();
        end
        req0 = 1'b0;
        repeat (2) step();
        sample();
        checkOutput("t5_pre_level", 32'(level), 32'd5);
        checkOutput("t5_pre_valid", 32'(out_valid), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        checkOutput("t5_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_level", 32'(level), 32'd0);
        checkOutput("t5_empty", 32'(empty), 32'd1);
        checkOutput("t5_fifo_rd", 32'(fifo_rd), 32'd0);

        // Random traffic; requesters hold data until granted.
        step();
        for (int c = 0; c < 10000; c++) begin
            sample();
            g0 = gnt0;
            g1 = gnt1;
            step();
            if (!req0 || g0) begin
                req0  = 1'($urandom_range(0, 1));
                data0 = 8'($urandom);
            end
            if (!req1 || g1) begin
                req1  = 1'($urandom_range(0, 1));
                data1 = 8'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (40) step();
        sample();
        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("final_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
